// File: rtl/psum_accum_buffer.sv
// -----------------------------------------------------------------------------
// psum_accum_buffer
//
// Receive-side partner of the kernel-channel PE array's partial-sum port.
// Captures one psum word (NUM_KERNEL lanes of 2*BIT_WIDTH bits) per output
// position of a tile and returns the stored word of the next position back to
// the PE, so that the PE accumulates across input-channel passes. After the
// last pass the finished tile is drained over a valid/ready stream.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_start           one-cycle pulse: latch config, start a tile
//   i_conf_depth      positions per tile (0 -> 1, >DEPTH -> DEPTH)
//   i_conf_num_pass   channel-group passes (0 -> 1)
//   i_psum            psum word from the PE, kernel k in lane k
//   i_psum_vld        per-kernel valid; a word is taken only when all ones
//   i_fb_adv          feeder advanced to the next feedback position
//   o_psum_fb         feedback psum to the PE (combinational)
//   o_out_data        drained tile word
//   o_out_vld         drain valid
//   i_out_rdy         drain ready
//   o_busy            high while accumulating or draining
//   o_done            one-cycle pulse after the last drain beat
//   err_flags         sticky errors: [0] partial valid, [1] valid outside
//                     ACCUM, [2] feedback advance outside ACCUM,
//                     [3] start while busy
// -----------------------------------------------------------------------------
module psum_accum_buffer #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int DEPTH      = 16,
    parameter int REG_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic [REG_WIDTH-1:0]                i_conf_depth,
    input  logic [REG_WIDTH-1:0]                i_conf_num_pass,
    input  logic [2*BIT_WIDTH*NUM_KERNEL-1:0]   i_psum,
    input  logic [NUM_KERNEL-1:0]               i_psum_vld,
    input  logic                                i_fb_adv,
    output logic [2*BIT_WIDTH*NUM_KERNEL-1:0]   o_psum_fb,
    output logic [2*BIT_WIDTH*NUM_KERNEL-1:0]   o_out_data,
    output logic                                o_out_vld,
    input  logic                                i_out_rdy,
    output logic                                o_busy,
    output logic                                o_done,
    output logic [REG_WIDTH-1:0]                err_flags
);

    localparam int WORD_W = 2 * BIT_WIDTH * NUM_KERNEL;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    logic [WORD_W-1:0]      mem_r [DEPTH];

    // Tile configuration is held as "last index" values so the wrap and
    // end-of-tile tests are plain equality compares.
    logic [PTR_W-1:0]       last_ptr_r;
    logic [REG_WIDTH-1:0]   last_pass_r;
    logic [PTR_W-1:0]       last_ptr_s;
    logic [REG_WIDTH-1:0]   last_pass_s;

    logic [PTR_W-1:0]       wr_ptr_r;
    logic [REG_WIDTH-1:0]   wr_pass_r;
    logic [PTR_W-1:0]       fb_ptr_r;
    logic [REG_WIDTH-1:0]   fb_pass_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       rd_next_s;

    logic                   vld_all_s;
    logic                   vld_part_s;
    logic                   wr_en_s;
    logic                   wr_last_s;
    logic                   fb_en_s;
    logic [REG_WIDTH-1:0]   err_set_s;

    // Clamp the requested tile geometry into last-index form.
    always_comb begin
        last_ptr_s  = '0;
        last_pass_s = '0;
        if (i_conf_depth == '0) begin
            last_ptr_s = '0;
        end else if (i_conf_depth > REG_WIDTH'(DEPTH)) begin
            last_ptr_s = PTR_W'(DEPTH - 1);
        end else begin
            last_ptr_s = PTR_W'(i_conf_depth - REG_WIDTH'(1));
        end
        if (i_conf_num_pass == '0) begin
            last_pass_s = '0;
        end else begin
            last_pass_s = i_conf_num_pass - REG_WIDTH'(1);
        end
    end

    // Decode write / feedback / error events for this cycle.
    always_comb begin
        vld_all_s  = &i_psum_vld;
        vld_part_s = (|i_psum_vld) & ~(&i_psum_vld);
        wr_en_s    = (state_r == ST_ACCUM) && vld_all_s;
        wr_last_s  = wr_en_s && (wr_ptr_r == last_ptr_r) && (wr_pass_r == last_pass_r);
        fb_en_s    = (state_r == ST_ACCUM) && i_fb_adv;
        rd_next_s  = rd_ptr_r + PTR_W'(1);
        err_set_s  = '0;
        err_set_s[0] = vld_part_s;
        err_set_s[1] = (state_r != ST_ACCUM) && (|i_psum_vld);
        err_set_s[2] = (state_r != ST_ACCUM) && i_fb_adv;
        err_set_s[3] = (state_r != ST_IDLE) && i_start;
    end

    // Feedback is read straight from the array, so a same-cycle write to the
    // same entry is not yet visible: the PE sees the pre-write value.
    always_comb begin
        o_psum_fb = '0;
        if ((state_r == ST_ACCUM) && (fb_pass_r != '0)) begin
            o_psum_fb = mem_r[fb_ptr_r];
        end else begin
            o_psum_fb = '0;
        end
    end

    // Psum storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_psum;
        end
    end

    // Control FSM with pointers and registered drain/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_ptr_r  <= '0;
            last_pass_r <= '0;
            wr_ptr_r    <= '0;
            wr_pass_r   <= '0;
            fb_ptr_r    <= '0;
            fb_pass_r   <= '0;
            rd_ptr_r    <= '0;
            o_out_data  <= '0;
            o_out_vld   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        state_r     <= ST_ACCUM;
                        o_busy      <= 1'b1;
                        last_ptr_r  <= last_ptr_s;
                        last_pass_r <= last_pass_s;
                        wr_ptr_r    <= '0;
                        wr_pass_r   <= '0;
                        fb_ptr_r    <= '0;
                        fb_pass_r   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (wr_en_s) begin
                        if (wr_ptr_r == last_ptr_r) begin
                            wr_ptr_r  <= '0;
                            wr_pass_r <= wr_pass_r + REG_WIDTH'(1);
                        end else begin
                            wr_ptr_r  <= wr_ptr_r + PTR_W'(1);
                        end
                        if (wr_last_s) begin
                            state_r  <= ST_DRAIN;
                            rd_ptr_r <= '0;
                        end
                    end
                    if (fb_en_s) begin
                        if (fb_ptr_r == last_ptr_r) begin
                            fb_ptr_r  <= '0;
                            fb_pass_r <= fb_pass_r + REG_WIDTH'(1);
                        end else begin
                            fb_ptr_r  <= fb_ptr_r + PTR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // rd_ptr_r always names the entry currently presented.
                    if (!o_out_vld) begin
                        o_out_vld  <= 1'b1;
                        o_out_data <= mem_r[rd_ptr_r];
                    end else if (i_out_rdy) begin
                        if (rd_ptr_r == last_ptr_r) begin
                            o_out_vld <= 1'b0;
                            o_busy    <= 1'b0;
                            o_done    <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            rd_ptr_r   <= rd_next_s;
                            o_out_data <= mem_r[rd_next_s];
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    o_busy    <= 1'b0;
                    o_out_vld <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flags <= '0;
        end else begin
            err_flags <= err_flags | err_set_s;
        end
    end

endmodule
